volume_meter: RTL and testbench
===============================

# volume_meter

Audio-level front end for the OLED volume-bar display. Consumes 12-bit microphone samples, tracks the peak magnitude over a fixed sample window, quantizes it to a 0–16 level with peak-hold and decay, and drives a 16-bit thermometer code. That code feeds both the board LEDs and the pixel renderer's `LED[15:0]` input, which draws the green, yellow and red bars from the set-bit count.

## Interface
Parameters:
- `WINDOW`, 4000: samples per measurement window (0.2 s at 20 kHz); legal range 2–65535.
- `FLOOR`, 2048: quiet-level sample value (mic DC midpoint); samples ≤ FLOOR map to level 0.
- `STEP_SHIFT`, 7: log2 of sample counts per level step (128).
- `DECAY_EN`, 1: 1 = displayed level falls at most 1 per window; 0 = level follows each window directly.

Ports:
- `my_clock` in 1: system clock; all state on rising edge.
- `my_reset_n` in 1: asynchronous, active-low reset.
- `mic_valid` in 1: one-cycle strobe; `mic_in` is sampled only when high. Any rate is legal, including every cycle.
- `mic_in` in 12: unsigned offset-binary sample.
- `freeze` in 1: while high, `level`/`led` hold their value. Window accumulation continues.
- `level` out 5: current displayed level, 0–16.
- `led` out 16: thermometer code; `led[i]` = 1 iff i < `level`.
- `level_valid` out 1: one-cycle pulse each time `level` is re-evaluated at a window end.

## Operation
- Sample counter `cnt` runs 0..WINDOW-1 and advances only on `mic_valid`. It wraps to 0 on the sample where `cnt == WINDOW-1`; that sample is the window-end sample.
- Peak accumulator `pk` (12 bit): on each non-final valid sample, `pk <= max(pk, mic_in)`. On the window-end sample:
  - window peak `wp = max(pk, mic_in)`;
  - `pk` clears to 0, so the next sample starts a fresh window.
- Quantization:
  - `d = wp - FLOOR` if `wp > FLOOR`, else 0.
  - `raw = (d + 2^STEP_SHIFT - 1) >> STEP_SHIFT`, saturated to 16.
  - With defaults: wp ≤ 2048 → 0; 2049–2176 → 1; 3969–4095 → 16.
  - Intermediate width is 13 bits, so there is no overflow.
- Level update on window end (when `freeze` = 0):
  - If `raw ≥ level`, or `DECAY_EN` = 0: `level <= raw`.
  - Otherwise: `level <= level - 1`.
- `freeze` = 1 at window end: `level` is unchanged, but `level_valid` still pulses.
- `led` is registered and always consistent with `level` (both update on the same edge).

## Timing
- Reset values: `level` = 0, `led` = 16'h0000, `level_valid` = 0, `cnt` = 0, `pk` = 0.
- Latency: `level`, `led` and `level_valid` change on the edge one cycle after the edge that samples the window-end `mic_valid`. `level_valid` is high for exactly that one cycle.
- Back-to-back valid samples: a sample in the cycle immediately after window end belongs to the new window and is never lost or double-counted.
- Reset mid-window discards the partial window; the first post-reset window is a full WINDOW samples.
- `mic_valid` low: no state changes except decay of `level_valid` to 0.
- `freeze` is sampled on the update edge only; toggling it between windows has no other effect.

## Structure
- Shared package `volume_pkg`:
  - `NUM_LEDS` = 16, `LEVEL_W` = 5, `SAMPLE_W` = 12;
  - `MIC_MIDPOINT` = 2048;
  - the thermometer-encode function, shared with any display block that needs a level-to-bar mapping.
- One combinational sub-module, `volume_quantize` (wp → raw), holds the FLOOR/STEP_SHIFT arithmetic and the saturation.
- The counter, accumulator and decay register stay in `volume_meter`.

## Test plan
Benches use WINDOW = 8 with other parameters at default unless stated.
- Reset then idle: `level` = 0 and `led` = 0x0000. After 8 samples of 2048, one `level_valid` pulse, `level` = 0.
- Window with a single 4095 sample among 2048s → `level` = 16 and `led` = 0xFFFF, one cycle after the 8th strobe. Then silent windows give 15, 14, 13 (DECAY_EN = 1). With DECAY_EN = 0, the first silent window gives 0.
- Boundary quantization: peaks of 2049 / 2176 / 2177 / 3968 / 3969 give levels 1 / 1 / 2 / 15 / 16. Expected `led` for the first case is 0x0001.
- `mic_valid` held high for 16 cycles, with sample 8 = 3000 and sample 9 = 4095:
  - first window → level 8 (0x00FF);
  - second window → 16;
  - exactly two `level_valid` pulses, 8 cycles apart.
- `freeze` high across a window with peak 4095 while `level` = 3: `level` stays 3 and `level_valid` still pulses. After `freeze` drops, the next window with peak 4095 → 16.
- Assert `my_reset_n` low after 5 samples including 4095, release, then feed 8 samples of 2048 → `level` = 0; the discarded peak does not appear.

Source files
------------

// File: rtl/volume_pkg.sv
// Shared constants and the level-to-bar thermometer encoder for the
// volume meter and any display block that draws level bars.
package volume_pkg;

   localparam int NUM_LEDS     = 16;
   localparam int LEVEL_W      = 5;
   localparam int SAMPLE_W     = 12;
   localparam int MIC_MIDPOINT = 2048;

   // Bit i is set iff i < lvl.
   function automatic logic [NUM_LEDS-1:0] thermo(
      input logic [LEVEL_W-1:0] lvl
   );
      logic [NUM_LEDS-1:0] t;
      t = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         t[i] = (i < int'(lvl));
      end
      return t;
   endfunction

endpackage

// File: rtl/volume_quantize.sv
// Window peak to bar level: subtract the quiet floor, round up to
// whole steps of 2^STEP_SHIFT and saturate at NUM_LEDS.
// Ports: wp = window peak sample, raw = level 0..16.
module volume_quantize
   import volume_pkg::*;
#(
   parameter int FLOOR      = MIC_MIDPOINT,
   parameter int STEP_SHIFT = 7
) (
   input  logic [SAMPLE_W-1:0] wp,
   output logic [LEVEL_W-1:0]  raw
);

   logic [12:0] d;
   logic [12:0] sum;
   logic [12:0] q;

   always_comb begin
      d = '0;
      if ({1'b0, wp} > 13'(FLOOR)) begin
         d = {1'b0, wp} - 13'(FLOOR);
      end
      sum = d + 13'((1 << STEP_SHIFT) - 1);
      q   = sum >> STEP_SHIFT;
      if (q > 13'(NUM_LEDS)) begin
         raw = LEVEL_W'(NUM_LEDS);
      end else begin
         raw = q[LEVEL_W-1:0];
      end
   end

endmodule

// File: rtl/volume_meter.sv
// Mic peak meter: per-window peak detect, quantize, peak-hold/decay.
// Ports: my_clock/my_reset_n, mic_valid/mic_in samples, freeze hold,
// level (0..16), led thermometer, level_valid per window end.
module volume_meter
   import volume_pkg::*;
#(
   parameter int WINDOW     = 4000,
   parameter int FLOOR      = MIC_MIDPOINT,
   parameter int STEP_SHIFT = 7,
   parameter bit DECAY_EN   = 1'b1
) (
   input  logic                my_clock,
   input  logic                my_reset_n,
   input  logic                mic_valid,
   input  logic [SAMPLE_W-1:0] mic_in,
   input  logic                freeze,
   output logic [LEVEL_W-1:0]  level,
   output logic [NUM_LEDS-1:0] led,
   output logic                level_valid
);

   logic [15:0]          cnt_q, cnt_d;
   logic [SAMPLE_W-1:0]  pk_q, pk_d;
   logic [SAMPLE_W-1:0]  wp_q, wp_d;
   logic                 end_q, end_d;
   logic [LEVEL_W-1:0]   level_q, level_d;
   logic [NUM_LEDS-1:0]  led_q, led_d;
   logic                 lv_q, lv_d;
   logic [SAMPLE_W-1:0]  pk_max;
   logic [LEVEL_W-1:0]   raw;

   // Quantizes the peak captured at the previous window end.
   volume_quantize #(
      .FLOOR      (FLOOR),
      .STEP_SHIFT (STEP_SHIFT)
   ) u_quant (
      .wp  (wp_q),
      .raw (raw)
   );

   always_comb begin
      cnt_d   = cnt_q;
      pk_d    = pk_q;
      wp_d    = wp_q;
      end_d   = 1'b0;
      level_d = level_q;
      lv_d    = 1'b0;
      pk_max  = (mic_in > pk_q) ? mic_in : pk_q;

      // Stage 1: accumulate, latch the window peak at window end.
      if (mic_valid) begin
         if (cnt_q == 16'(WINDOW - 1)) begin
            cnt_d = '0;
            pk_d  = '0;
            wp_d  = pk_max;
            end_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 16'd1;
            pk_d  = pk_max;
         end
      end

      // Stage 2: level update one cycle later; freeze sampled here.
      if (end_q) begin
         lv_d = 1'b1;
         if (!freeze) begin
            if (raw >= level_q || !DECAY_EN) begin
               level_d = raw;
            end else begin
               level_d = level_q - LEVEL_W'(1);
            end
         end
      end

      led_d = thermo(level_d);
   end

   always_ff @(posedge my_clock or negedge my_reset_n) begin
      if (!my_reset_n) begin
         cnt_q   <= '0;
         pk_q    <= '0;
         wp_q    <= '0;
         end_q   <= 1'b0;
         level_q <= '0;
         led_q   <= '0;
         lv_q    <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         pk_q    <= pk_d;
         wp_q    <= wp_d;
         end_q   <= end_d;
         level_q <= level_d;
         led_q   <= led_d;
         lv_q    <= lv_d;
      end
   end

   assign level       = level_q;
   assign led         = led_q;
   assign level_valid = lv_q;

endmodule

// File: tb/tb_volume_meter.sv
// Directed bench for volume_meter with WINDOW = 8; a second instance
// with DECAY_EN = 0 shares the stimulus.
module tb_volume_meter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mic_valid = 1'b0;
   logic [11:0] mic_in = 12'd2048;
   logic        freeze = 1'b0;
   logic [4:0]  level, level_nd;
   logic [15:0] led, led_nd;
   logic        lv, lv_nd;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   volume_meter #(.WINDOW(8)) u_dut (
      .my_clock    (clk),
      .my_reset_n  (rst_n),
      .mic_valid   (mic_valid),
      .mic_in      (mic_in),
      .freeze      (freeze),
      .level       (level),
      .led         (led),
      .level_valid (lv)
   );

   volume_meter #(.WINDOW(8), .DECAY_EN(1'b0)) u_nd (
      .my_clock    (clk),
      .my_reset_n  (rst_n),
      .mic_valid   (mic_valid),
      .mic_in      (mic_in),
      .freeze      (freeze),
      .level       (level_nd),
      .led         (led_nd),
      .level_valid (lv_nd)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      mic_valid = 1'b0;
      freeze    = 1'b0;
      rst_n     = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic send(input logic [11:0] s);
      @(negedge clk);
      mic_valid = 1'b1;
      mic_in    = s;
      @(negedge clk);
      mic_valid = 1'b0;
      mic_in    = 12'd2048;
   endtask

   // Eight samples, peak at position 3; returns at the negedge
   // where the update is visible.
   task automatic window(input logic [11:0] pk);
      for (int i = 0; i < 8; i++) begin
         send((i == 3) ? pk : 12'd2048);
      end
      @(negedge clk);
   endtask

   logic [11:0] bpk [5] = '{12'd2049, 12'd2176, 12'd2177,
                            12'd3968, 12'd3969};
   logic [4:0]  blv [5] = '{5'd1, 5'd1, 5'd2, 5'd15, 5'd16};

   initial begin
      int npulse;
      int first_c;
      int last_c;
      logic [4:0]  l1;
      logic [15:0] led1;
      logic [4:0]  l2;

      do_reset();
      #1;
      chk("rst_level", level, 5'd0);
      chk("rst_led", led, 16'h0000);
      chk("rst_lv", lv, 1'b0);
      repeat (5) @(negedge clk);
      chk("idle_lv", lv, 1'b0);

      window(12'd2048);
      chk("quiet_lv", lv, 1'b1);
      chk("quiet_level", level, 5'd0);
      @(negedge clk);
      chk("quiet_lv_drop", lv, 1'b0);

      window(12'd4095);
      chk("loud_level", level, 5'd16);
      chk("loud_led", led, 16'hFFFF);
      chk("loud_nd", level_nd, 5'd16);
      window(12'd2048);
      chk("decay15", level, 5'd15);
      chk("decay15_led", led, 16'h7FFF);
      chk("nodecay0", level_nd, 5'd0);
      chk("nodecay0_led", led_nd, 16'h0000);
      window(12'd2048);
      chk("decay14", level, 5'd14);
      window(12'd2048);
      chk("decay13", level, 5'd13);

      do_reset();
      for (int k = 0; k < 5; k++) begin
         window(bpk[k]);
         chk($sformatf("bound_%0d", bpk[k]), level, blv[k]);
         if (k == 0) chk("bound_led", led, 16'h0001);
      end

      do_reset();
      npulse  = 0;
      first_c = -1;
      last_c  = -1;
      l1 = '0; led1 = '0; l2 = '0;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         if (lv) begin
            npulse++;
            if (first_c < 0) begin
               first_c = c;
               l1      = level;
               led1    = led;
            end else begin
               l2 = level;
            end
            last_c = c;
         end
         mic_valid = (c < 16);
         mic_in    = (c == 7) ? 12'd3000 :
                     (c == 8) ? 12'd4095 : 12'd2048;
      end
      chk("b2b_pulses", npulse, 2);
      chk("b2b_first_c", first_c, 9);
      chk("b2b_gap", last_c - first_c, 8);
      chk("b2b_lvl1", l1, 5'd8);
      chk("b2b_led1", led1, 16'h00FF);
      chk("b2b_lvl2", l2, 5'd16);

      do_reset();
      window(12'd2348);
      chk("pre_freeze", level, 5'd3);
      freeze = 1'b1;
      window(12'd4095);
      chk("frz_level", level, 5'd3);
      chk("frz_led", led, 16'h0007);
      chk("frz_lv", lv, 1'b1);
      freeze = 1'b0;
      window(12'd4095);
      chk("unfrz_level", level, 5'd16);

      do_reset();
      for (int i = 0; i < 5; i++) begin
         send((i == 2) ? 12'd4095 : 12'd2048);
      end
      do_reset();
      for (int i = 0; i < 7; i++) send(12'd2048);
      @(negedge clk);
      chk("mid_rst_partial", lv, 1'b0);
      send(12'd2048);
      @(negedge clk);
      chk("mid_rst_lv", lv, 1'b1);
      chk("mid_rst_level", level, 5'd0);
      chk("mid_rst_led", led, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
